// File: rtl/mantissa_mult_pipe.sv
// mantissa_mult_pipe: stalled valid/ready mantissa multiplier with normalisation and guard/round/sticky extraction.
// Define ROUND_RNE_EN to add a round-to-nearest-even output stage (latency STAGES+1).
module mantissa_mult_pipe #(
  parameter int MW = 24,
  parameter int STAGES = 3,
  parameter int TAG_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MW-1:0]     in_a,
  input  logic [MW-1:0]     in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*MW-1:0]   out_prod,
  output logic              out_hi,
  output logic [MW-1:0]     out_mant,
  output logic [2:0]        out_grs,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_exp_inc
);
  localparam int L = STAGES - 1;
  logic              w_adv;
  logic              r_v1;
  logic [MW-1:0]     r_a, r_b;
  logic [TAG_W-1:0]  r_t1;
  logic              r_pv [2:L];
  logic [2*MW-1:0]   r_pp [2:L];
  logic [TAG_W-1:0]  r_pt [2:L];
  logic              r_fv, r_fhi;
  logic [2*MW-1:0]   r_fp;
  logic [MW-1:0]     r_fm;
  logic [2:0]        r_fgrs;
  logic [TAG_W-1:0]  r_ft;
  logic [2*MW-1:0]   w_mul, w_p;
  logic              w_hi;
  logic [MW-1:0]     w_m;
  logic [2:0]        w_grs;
  assign w_adv = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_mul = {{MW{1'b0}}, r_a} * {{MW{1'b0}}, r_b};
  assign w_p = r_pp[L];
  always_comb begin
    w_hi = w_p[2*MW-1];
    w_m = w_hi ? w_p[2*MW-1:MW] : w_p[2*MW-2:MW-1];
    w_grs = w_hi ? {w_p[MW-1], w_p[MW-2], |w_p[MW-3:0]} : {w_p[MW-2], w_p[MW-3], |w_p[MW-4:0]};
  end
`ifdef ROUND_RNE_EN
  logic              r_ov, r_ohi, r_oe;
  logic [2*MW-1:0]   r_op;
  logic [MW-1:0]     r_om;
  logic [2:0]        r_ogrs;
  logic [TAG_W-1:0]  r_ot;
  logic              w_inc, w_c;
  logic [MW-1:0]     w_sum, w_rm;
  // an all-ones mantissa rounds up to 1.0 of the next binade
  always_comb begin
    w_inc = r_fgrs[2] && (r_fgrs[1] || r_fgrs[0] || r_fm[0]);
    {w_c, w_sum} = {1'b0, r_fm} + {{MW{1'b0}}, w_inc};
    w_rm = w_c ? {1'b1, {(MW-1){1'b0}}} : w_sum;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ov <= 1'b0;
    end else if (flush) begin
      r_ov <= 1'b0;
    end else if (w_adv) begin
      r_ov <= r_fv;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op <= '0;
      r_ohi <= 1'b0;
      r_om <= '0;
      r_ogrs <= '0;
      r_ot <= '0;
      r_oe <= 1'b0;
    end else if (w_adv) begin
      r_op <= r_fp;
      r_ohi <= r_fhi;
      r_om <= w_rm;
      r_ogrs <= r_fgrs;
      r_ot <= r_ft;
      r_oe <= r_fhi || w_c;
    end
  assign out_valid = r_ov;
  assign out_prod = r_op;
  assign out_hi = r_ohi;
  assign out_mant = r_om;
  assign out_grs = r_ogrs;
  assign out_tag = r_ot;
  assign out_exp_inc = r_oe;
`else
  assign out_valid = r_fv;
  assign out_prod = r_fp;
  assign out_hi = r_fhi;
  assign out_mant = r_fm;
  assign out_grs = r_fgrs;
  assign out_tag = r_ft;
  assign out_exp_inc = r_fhi;
`endif
  // flush clears valids even while stalled; data simply follows adv
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v1 <= 1'b0;
      r_fv <= 1'b0;
      for (int k = 2; k <= L; k++) r_pv[k] <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_fv <= 1'b0;
      for (int k = 2; k <= L; k++) r_pv[k] <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_pv[2] <= r_v1;
      for (int k = 3; k <= L; k++) r_pv[k] <= r_pv[k-1];
      r_fv <= r_pv[L];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_t1 <= '0;
      for (int k = 2; k <= L; k++) begin
        r_pp[k] <= '0;
        r_pt[k] <= '0;
      end
      r_fp <= '0;
      r_fhi <= 1'b0;
      r_fm <= '0;
      r_fgrs <= '0;
      r_ft <= '0;
    end else if (w_adv) begin
      r_a <= in_a;
      r_b <= in_b;
      r_t1 <= in_tag;
      r_pp[2] <= w_mul;
      r_pt[2] <= r_t1;
      for (int k = 3; k <= L; k++) begin
        r_pp[k] <= r_pp[k-1];
        r_pt[k] <= r_pt[k-1];
      end
      r_fp <= w_p;
      r_fhi <= w_hi;
      r_fm <= w_m;
      r_fgrs <= w_grs;
      r_ft <= r_pt[L];
    end
endmodule

// File: doc/mantissa_mult_pipe.md
Name: mantissa_mult_pipe

Overview:
Parametrised, valid/ready-handshaked pipelined mantissa multiplier with built-in post-multiply normalisation and guard/round/sticky extraction. It sits in the FP multiply datapath between exponent/sign pre-processing and the rounding/packing stage. A side-band tag travels alongside each operand pair so the caller can carry sign and exponent through the pipeline. A backpressure-aware global stall replaces the free-running pipeline of the previous generation.

Parameters:
MW, 24, mantissa width including hidden bit (>=4)
STAGES, 3, register stages from input to output (>=3)
TAG_W, 10, side-band tag width (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of all in-flight valids
in_valid  in  1  operand pair valid
in_ready  out  1  pipeline can accept
in_a  in  MW  mantissa A
in_b  in  MW  mantissa B
in_tag  in  TAG_W  side-band, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_prod  out  2*MW  raw product
out_hi  out  1  product MSB (product in [2,4) range)
out_mant  out  MW  normalised mantissa
out_grs  out  3  {guard, round, sticky}
out_tag  out  TAG_W  tag of this result
out_exp_inc  out  1  exponent increment required (= out_hi; OR rounding carry when ROUND_RNE_EN is set)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valids 0 and all data registers 0, so out_valid=0, out_prod=0, out_hi=0, out_mant=0, out_grs=0, out_tag=0, out_exp_inc=0.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=0, every stage, including valids, holds.
  - When adv=1, every stage shifts by one.
  - A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
- Stage 1: register in_a, in_b, in_tag and the valid bit.
- Stage 2: register the full 2*MW product of the stage-1 operands.
- Stages 3..STAGES-1: pure delay of product, tag and valid.
- Final stage: register the normalised fields, computed combinationally from the previous stage:
  - hi = prod[2MW-1].
  - hi=1: mant = prod[2MW-1:MW], G = prod[MW-1], R = prod[MW-2], S = |prod[MW-3:0].
  - hi=0: mant = prod[2MW-2:MW-1], G = prod[MW-2], R = prod[MW-3], S = |prod[MW-4:0].
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready=1.
- Order: results emerge in input order; none are lost or duplicated under any out_ready pattern.
- Data stability: while out_valid=1 and out_ready=0, all out_* stay stable.
- flush=1: all valid bits clear on the next edge, regardless of adv. in_ready must read 1 in the following cycle.
  - flush coincident with in_valid: the input is discarded.
- Non-normalised operands (hidden bit 0) are multiplied as plain integers. out_hi=0 with a product MSB-1 of 0 is legal and is not flagged.
- Reset asserted mid-operation clears all valids immediately (asynchronously). No partial results appear after release.

Optional Feature:
Macro ROUND_RNE_EN.
- Defined: one extra register stage, so latency = STAGES+1.
  - Applies round-to-nearest-even: increment mant when G && (R || S || mant[0]).
  - Increment overflow (all-ones mant): out_mant = 1 followed by MW-1 zeros (for MW=24: 0x800000), and out_exp_inc=1.
  - out_exp_inc = out_hi OR rounding carry.
  - out_grs is reported pre-rounding.
- Undefined: no rounding; latency = STAGES; out_exp_inc = out_hi.

Test Plan:
- MW=24, in_a=in_b=0x800000 (1.0×1.0) -> after 3 cycles: out_prod=0x400000000000, out_hi=0, out_mant=0x800000, out_grs=000, out_exp_inc=0.
- in_a=in_b=0xC00000 (1.5×1.5) -> out_prod=0x900000000000, out_hi=1, out_mant=0x900000, out_grs=000, out_exp_inc=1.
- in_a=in_b=0xFFFFFF -> out_prod=0xFFFFFE000001, out_hi=1, out_mant=0xFFFFFE, out_grs=001. The same result with ROUND_RNE_EN (G=0, so no increment).
- Stream 20 random pairs with tags 0..19 while toggling out_ready pseudo-randomly -> all 20 results in tag order, each equal to a*b. Outputs stay stable during every stall. in_ready=0 only when out_valid=1 && out_ready=0.
- Fill the pipeline with 3 entries holding out_ready=0, then pulse flush -> out_valid=0 and in_ready=1 next cycle. A new input with tag 0x2A emerges 3 cycles after acceptance.
- Assert rst for 1 cycle mid-stream with 2 entries in flight -> out_valid drops to 0 without waiting for a clock edge; no stale results after release. All outputs read 0.
